uart_tx: RTL

UART transmitter paired with the 8x-oversampling receiver in the UART block.
- Serialises one byte per frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Uses the same 8x baud tick (bd8_rate) as the receiver, so each bit lasts exactly 8 ticks.
- Accepts bytes from system logic through a valid/ready handshake on clk.

---
 rtl/uart_tx_if.sv | 13 +
 rtl/uart_tx.sv | 99 +++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out bundle between system logic and the UART transmitter.
// The master drives bytes and the 8x baud tick; the slave drives the line and status.
interface uart_tx_if;
  logic       bd8_rate;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;

  modport master (output bd8_rate, tx_data, tx_valid, input tx_ready, tx, tx_busy);
  modport slave  (input bd8_rate, tx_data, tx_valid, output tx_ready, tx, tx_busy);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits, 8 ticks per bit.
// One byte accepted per frame, only in IDLE; the start bit goes out on the first tick after acceptance.
module uart_tx #(
  parameter string PARITY   = "ODD",
  parameter int    STOP_BIT = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam bit PAR_EN   = (PARITY == "ODD") || (PARITY == "EVEN");
  localparam bit PAR_ODD  = (PARITY == "ODD");
  localparam bit TWO_STOP = (STOP_BIT == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_tick;
  logic [2:0] r_bit;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_par;
  logic       r_tx, w_tx_nxt;
  logic       w_accept;
  logic       w_bit_end;

  assign w_accept  = (r_state == S_IDLE) && bus.tx_valid;
  assign w_bit_end = bus.bd8_rate && (r_tick == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)        w_state_nxt = S_WAIT;
      S_WAIT:   if (bus.bd8_rate)    w_state_nxt = S_START;
      S_START:  if (w_bit_end)       w_state_nxt = S_DATA;
      S_DATA:   if (w_bit_end && (r_bit == 3'd7))
                  w_state_nxt = PAR_EN ? S_PARITY : S_STOP1;
      S_PARITY: if (w_bit_end)       w_state_nxt = S_STOP1;
      S_STOP1:  if (w_bit_end)       w_state_nxt = TWO_STOP ? S_STOP2 : S_IDLE;
      S_STOP2:  if (w_bit_end)       w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  // Line level is decided from the next state so tx changes on the same edge as the state.
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_accept)
      w_shift_nxt = bus.tx_data;
    else if ((r_state == S_DATA) && w_bit_end)
      w_shift_nxt = {1'b0, r_shift[7:1]};

    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = r_par;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick  <= 3'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_tx    <= w_tx_nxt;
      r_shift <= w_shift_nxt;
      if (w_accept) begin
        r_par  <= PAR_ODD ? ~^bus.tx_data : ^bus.tx_data;
        r_bit  <= 3'd0;
        r_tick <= 3'd0;
      end
      // The tick that leaves WAIT is T0; the counter restarts there and wraps every 8 ticks.
      if (r_state == S_WAIT) begin
        if (bus.bd8_rate) r_tick <= 3'd0;
      end else if ((r_state != S_IDLE) && bus.bd8_rate) begin
        r_tick <= r_tick + 3'd1;
      end
      if ((r_state == S_DATA) && w_bit_end)
        r_bit <= r_bit + 3'd1;
    end
  end

  assign bus.tx       = r_tx;
  assign bus.tx_ready = (r_state == S_IDLE);
  assign bus.tx_busy  = (r_state != S_IDLE);

endmodule
